// File: rtl/jogo_pkg.sv
// Shared constants for the game's serial state transmitter: FSM codes and frame bytes.
package jogo_pkg;

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        CABECALHO = 4'd1,
        CONTAGEM  = 4'd2,
        BUSCA     = 4'd3,
        DADOS     = 4'd4,
        CHECKSUM  = 4'd5,
        FIM       = 4'd6
    } estado_t;

    localparam logic [7:0] HEADER_FRAME = 8'hA5;
    localparam logic       START        = 1'b0;
    localparam logic       STOP         = 1'b1;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first. A new byte may be launched in the last stop-bit
// cycle so consecutive bytes leave no idle gap on the line.
module uart_tx_byte
    import jogo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dado,
    output logic       saida,
    output logic       fim_byte,
    output logic       ocupado
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    ULTIMO_BIT = 4'd9;

    logic [9:0]    shreg;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic          busy;

    assign fim_byte = busy && (cnt == CNT_MAX) && (bit_idx == ULTIMO_BIT);
    assign saida    = busy ? shreg[0] : STOP;
    assign ocupado  = busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg   <= '1;
            cnt     <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
        end else if (partida && (!busy || fim_byte)) begin
            shreg   <= {STOP, dado, START};
            cnt     <= '0;
            bit_idx <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                if (bit_idx == ULTIMO_BIT) begin
                    busy <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    shreg   <= {STOP, shreg[9:1]};
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/transmissor_estado_jogo.sv
// Frame sequencer: header, count, N memory entries and XOR checksum sent back to back,
// with each entry prefetched from position memory while the previous byte is on the line.
module transmissor_estado_jogo
    import jogo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int N_ENTRADAS   = 32,
    parameter int END_W        = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enviar,
    output logic [END_W-1:0] end_leitura,
    input  logic [7:0]       dado_leitura,
    output logic             saida_serial,
    output logic             ocupado,
    output logic             pronto,
    output logic [3:0]       db_estado
);

    localparam logic [7:0] N_BYTE = 8'(N_ENTRADAS);
    localparam logic [7:0] ULTIMO = 8'(N_ENTRADAS - 1);

    estado_t    estado, prox;
    logic [7:0] idx, chk, buffer;
    logic       espera, chk_lancado;
    logic       partida, fim_byte, tx_ocupado;
    logic [7:0] tx_dado;
    logic       aceitar, capturar, lancar_entrada, lancar_chk;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clock    (clock),
        .reset    (reset),
        .partida  (partida),
        .dado     (tx_dado),
        .saida    (saida_serial),
        .fim_byte (fim_byte),
        .ocupado  (tx_ocupado)
    );

    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox;
    end

    always_comb begin
        prox           = estado;
        partida        = 1'b0;
        tx_dado        = HEADER_FRAME;
        aceitar        = 1'b0;
        capturar       = 1'b0;
        lancar_entrada = 1'b0;
        lancar_chk     = 1'b0;
        case (estado)
            // fim behaves as ocioso for acceptance so frames can run back to back
            OCIOSO, FIM: begin
                prox = OCIOSO;
                if (enviar && !tx_ocupado) begin
                    aceitar = 1'b1;
                    partida = 1'b1;
                    prox    = CABECALHO;
                end
            end
            CABECALHO: if (fim_byte) begin
                partida = 1'b1;
                tx_dado = N_BYTE;
                prox    = CONTAGEM;
            end
            CONTAGEM: prox = BUSCA;
            // memory is registered: wait one cycle after the address settles
            BUSCA: if (espera) begin
                capturar = 1'b1;
                prox     = DADOS;
            end
            DADOS: if (fim_byte) begin
                partida        = 1'b1;
                tx_dado        = buffer;
                lancar_entrada = 1'b1;
                prox           = (idx < ULTIMO) ? BUSCA : CHECKSUM;
            end
            // first fim_byte ends the last entry, the second ends the checksum
            CHECKSUM: if (fim_byte) begin
                if (!chk_lancado) begin
                    partida    = 1'b1;
                    tx_dado    = chk;
                    lancar_chk = 1'b1;
                end else begin
                    prox = FIM;
                end
            end
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx         <= '0;
            chk         <= '0;
            buffer      <= '0;
            espera      <= 1'b0;
            chk_lancado <= 1'b0;
        end else begin
            espera <= (estado == BUSCA);
            if (aceitar) begin
                idx         <= '0;
                chk         <= N_BYTE;
                chk_lancado <= 1'b0;
            end
            if (capturar) buffer <= dado_leitura;
            if (lancar_entrada) begin
                chk <= chk ^ buffer;
                if (idx < ULTIMO) idx <= idx + 8'd1;
            end
            if (lancar_chk) chk_lancado <= 1'b1;
        end
    end

    assign end_leitura = END_W'(idx);
    assign ocupado     = (estado != OCIOSO) && (estado != FIM);
    assign pronto      = (estado == FIM);
    assign db_estado   = estado;

endmodule

// File: tb/tb_transmissor_estado_jogo.sv
// Directed bench: cycle-exact line check of whole frames, reset, back-to-back and address range.
module tb_transmissor_estado_jogo;

    localparam int CPB = 4;
    localparam int N   = 3;
    localparam int EW  = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enviar = 1'b0;
    logic [EW-1:0] end_leitura;
    logic [7:0]    dado_leitura = 8'h00;
    logic          saida_serial, ocupado, pronto;
    logic [3:0]    db_estado;

    logic [7:0] mem [0:3];
    bit         addr_bad = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    transmissor_estado_jogo #(.CLKS_PER_BIT(CPB), .N_ENTRADAS(N), .END_W(EW)) dut (
        .clock        (clock),
        .reset        (reset),
        .enviar       (enviar),
        .end_leitura  (end_leitura),
        .dado_leitura (dado_leitura),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // registered position memory: data valid one cycle after the address
    always @(posedge clock) dado_leitura <= mem[end_leitura];

    always @(negedge clock)
        if (!reset && end_leitura > 2'd2) addr_bad = 1'b1;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Called at cycle A+1; checks every line cycle of the frame, then the pronto cycle.
    task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] echk, input bit keep_enviar, input string nome);
        logic [7:0] exp_b [0:N+2];
        logic [7:0] got;
        logic       expbit, err;
        exp_b[0] = 8'hA5; exp_b[1] = 8'h03;
        exp_b[2] = e0; exp_b[3] = e1; exp_b[4] = e2; exp_b[5] = echk;
        if (!keep_enviar) enviar = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd1 || ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL %s start: estado=%0d ocupado=%b, want 1/1", nome, db_estado, ocupado);
        end
        for (int b = 0; b < N + 3; b++) begin
            err = 1'b0;
            got = 8'h00;
            for (int j = 0; j < 10; j++) begin
                for (int c = 0; c < CPB; c++) begin
                    expbit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[b][j-1];
                    if (saida_serial !== expbit || ocupado !== 1'b1 || pronto !== 1'b0) err = 1'b1;
                    if (c == CPB / 2 && j >= 1 && j <= 8) got[j-1] = saida_serial;
                    if (b >= 1 && b <= N && j == 9 && c == CPB - 1) begin
                        n_cmp++;
                        if (end_leitura !== EW'(b - 1)) begin
                            n_err++;
                            $display("FAIL %s addr before entry %0d: got %0d want %0d",
                                     nome, b - 1, end_leitura, b - 1);
                        end
                    end
                    tick();
                end
            end
            n_cmp++;
            if (err || got !== exp_b[b]) begin
                n_err++;
                $display("FAIL %s byte%0d: got %h want %h framing_err=%0b", nome, b, got, exp_b[b], err);
            end
        end
        n_cmp++;
        if (pronto !== 1'b1 || ocupado !== 1'b0 || saida_serial !== 1'b1 || db_estado !== 4'd6) begin
            n_err++;
            $display("FAIL %s pronto cycle: pronto=%b ocupado=%b line=%b estado=%0d want 1/0/1/6",
                     nome, pronto, ocupado, saida_serial, db_estado);
        end
    endtask

    task automatic check_idle(input int ciclos, input string nome);
        bit bad = 1'b0;
        for (int i = 0; i < ciclos; i++) begin
            tick();
            if (ocupado !== 1'b0 || saida_serial !== 1'b1 || pronto !== 1'b0 || db_estado !== 4'd0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL %s idle: ocupado=%b line=%b pronto=%b estado=%0d want 0/1/0/0",
                     nome, ocupado, saida_serial, pronto, db_estado);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 ||
            db_estado !== 4'd0 || end_leitura !== 2'd0) begin
            n_err++;
            $display("FAIL reset: line=%b ocupado=%b pronto=%b estado=%0d addr=%0d want 1/0/0/0/0",
                     saida_serial, ocupado, pronto, db_estado, end_leitura);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_frame;
        enviar = 1'b1;
        tick();
        run_frame(8'h12, 8'h34, 8'hF0, 8'hD5, 1'b0, "frame");
        check_idle(5, "frame");
    endtask

    task automatic test_back_to_back;
        enviar = 1'b1;
        tick();
        run_frame(8'h12, 8'h34, 8'hF0, 8'hD5, 1'b1, "b2b_first");
        tick();
        run_frame(8'h12, 8'h34, 8'hF0, 8'hD5, 1'b0, "b2b_second");
        check_idle(20, "b2b");
    endtask

    task automatic test_reset_mid_frame;
        enviar = 1'b1;
        tick();
        enviar = 1'b0;
        repeat (82) tick();
        n_cmp++;
        if (ocupado !== 1'b1 || db_estado === 4'd0) begin
            n_err++;
            $display("FAIL midreset pre: ocupado=%b estado=%0d want busy", ocupado, db_estado);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL midreset: line=%b ocupado=%b pronto=%b estado=%0d want 1/0/0/0",
                     saida_serial, ocupado, pronto, db_estado);
        end
        tick();
        reset = 1'b0;
        tick();
        enviar = 1'b1;
        tick();
        run_frame(8'h12, 8'h34, 8'hF0, 8'hD5, 1'b0, "after_reset");
        tick();
    endtask

    task automatic test_zero_data;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        enviar = 1'b1;
        tick();
        run_frame(8'h00, 8'h00, 8'h00, 8'h03, 1'b0, "zeros");
        tick();
    endtask

    task automatic test_addr_monitor;
        n_cmp++;
        if (addr_bad) begin
            n_err++;
            $display("FAIL addr_range: got out-of-range address seen=1 want 0");
        end
    endtask

    initial begin
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hF0; mem[3] = 8'hEE;
        test_reset();
        test_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_zero_data();
        test_addr_monitor();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
